// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment slot scheduler.
package seg_pkg;
    localparam int unsigned NUM_DIGITS    = 6;
    localparam int unsigned SEG_W         = 7;
    localparam int unsigned DIGITS_W      = NUM_DIGITS * SEG_W;
    localparam int unsigned FRAME_LEN_DEF = 900;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        S_WAIT,
        S_DRIVE,
        S_BLANK
    } slot_state_t;

    // Digit 0 sits in the low bits (seconds units), digit 5 in the top bits.
    function automatic logic [SEG_W-1:0] digit_of(input logic [DIGITS_W-1:0] digits,
                                                  input int unsigned k);
        return digits[k*SEG_W +: SEG_W];
    endfunction
endpackage

// File: rtl/seg_slot_scheduler_if.sv
// Digit sources in, segment/enable bus and source-switch status out.
interface seg_slot_scheduler_if;
    import seg_pkg::*;

    logic [DIGITS_W-1:0]   time_digits;
    logic [DIGITS_W-1:0]   alt_digits;
    logic                  alt_req;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [SEG_W-1:0]      seg_out;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                  frame_start;
    logic                  src_alt;
    logic                  alt_ack;

    modport master (
        output time_digits, alt_digits, alt_req, blink_mask,
        input  seg_out, digit_sel, frame_start, src_alt, alt_ack
    );

    modport slave (
        input  time_digits, alt_digits, alt_req, blink_mask,
        output seg_out, digit_sel, frame_start, src_alt, alt_ack
    );
endinterface

// File: rtl/seg_slot_scheduler_frame_timer.sv
// Frame counter running 1..FRAME_LEN with a boundary strobe and a registered frame_start.
module frame_timer
    import seg_pkg::*;
#(
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             frame_start,
    output logic             wrap
);
    assign wrap = (cnt == CNT_W'(FRAME_LEN));

    // frame_start is high exactly while cnt==1 following a wrap, never right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= CNT_W'(1);
            frame_start <= 1'b0;
        end else begin
            cnt         <= wrap ? CNT_W'(1) : cnt + 1'b1;
            frame_start <= wrap;
        end
    end
endmodule

// File: rtl/seg_slot_scheduler.sv
// Six-digit display scheduler: per-digit slot FSMs, frame snapshot buffer,
// blink phase and time/alt source arbitration at frame boundaries.
module seg_slot_scheduler
    import seg_pkg::*;
#(
    parameter int unsigned FRAME_LEN    = FRAME_LEN_DEF,
    parameter int unsigned SLOT0        = 1,
    parameter int unsigned SLOT1        = 5,
    parameter int unsigned SLOT2        = 28,
    parameter int unsigned SLOT3        = 34,
    parameter int unsigned SLOT4        = 57,
    parameter int unsigned SLOT5        = 62,
    parameter int unsigned ON_LEN       = 1,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input logic                 clk,
    input logic                 rst,
    seg_slot_scheduler_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned SLOT [NUM_DIGITS] = '{SLOT0, SLOT1, SLOT2, SLOT3, SLOT4, SLOT5};

    if (ON_LEN < 1) begin : g_bad_on_len
        $error("ON_LEN must be at least 1");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("BLINK_FRAMES must be at least 1");
    end
    if (SLOT0 < 1) begin : g_bad_slot0
        $error("SLOT0 must be at least 1");
    end
    if (SLOT5 + ON_LEN + 1 > FRAME_LEN) begin : g_bad_last
        $error("last slot does not fit in the frame");
    end
    for (genvar k = 0; k < NUM_DIGITS - 1; k++) begin : g_chk
        if (SLOT[k+1] <= SLOT[k] || SLOT[k] + ON_LEN + 1 > SLOT[k+1]) begin : g_bad_order
            $error("slots overlap or are not strictly increasing");
        end
    end

    logic [CNT_W-1:0]      cnt;
    logic                  frame_start_i;
    logic                  wrap;
    slot_state_t           state_q [NUM_DIGITS];
    slot_state_t           state_d [NUM_DIGITS];
    logic [DIGITS_W-1:0]   frame_buf;
    logic                  src_alt_q;
    logic                  alt_ack_q;
    logic                  armed;
    logic                  blink_phase;
    logic [BLK_W-1:0]      blink_cnt;
    logic [SEG_W-1:0]      seg_d;
    logic [NUM_DIGITS-1:0] sel_d;

    frame_timer #(.FRAME_LEN(FRAME_LEN)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .cnt         (cnt),
        .frame_start (frame_start_i),
        .wrap        (wrap)
    );

    // Slots stay idle until the first boundary so the post-reset frame is fully dark.
    always_comb begin
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                S_WAIT:  if (armed && cnt == CNT_W'(SLOT[k])) state_d[k] = S_DRIVE;
                S_DRIVE: if (cnt == CNT_W'(SLOT[k] + ON_LEN)) state_d[k] = S_BLANK;
                S_BLANK: state_d[k] = S_WAIT;
                default: state_d[k] = S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) state_q[k] <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        seg_d = SEG_BLANK;
        sel_d = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (state_q[k] == S_DRIVE) begin
                sel_d[k] = 1'b1;
                if (!(bus.blink_mask[k] && blink_phase)) seg_d = digit_of(frame_buf, k);
            end
        end
    end

    // Source, snapshot and blink phase all change together on the wrap edge only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_buf   <= '0;
            src_alt_q   <= 1'b0;
            alt_ack_q   <= 1'b0;
            armed       <= 1'b0;
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
        end else begin
            alt_ack_q <= 1'b0;
            if (wrap) begin
                armed     <= 1'b1;
                src_alt_q <= bus.alt_req;
                alt_ack_q <= (bus.alt_req != src_alt_q);
                frame_buf <= bus.alt_req ? bus.alt_digits : bus.time_digits;
                if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.seg_out     = seg_d;
    assign bus.digit_sel   = sel_d;
    assign bus.frame_start = frame_start_i;
    assign bus.src_alt     = src_alt_q;
    assign bus.alt_ack     = alt_ack_q;
endmodule

// File: doc/seg_slot_scheduler.md
SEG_SLOT_SCHEDULER -- requirements
Module: seg_slot_scheduler

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 900, meaning clk cycles per display frame.
REQ-002 SHALL have parameter SLOT0..SLOT5, defaults 1,5,28,34,57,62, meaning the count value that starts digit k's slot.
REQ-003 SHALL have parameter ON_LEN, default 1, meaning cycles each digit is driven.
REQ-004 SHALL have parameter BLINK_FRAMES, default 32, meaning frames per blink phase.
REQ-005 SHALL have one clock and one reset: clk is the only clock; rst is asynchronous, active-high.
REQ-006 SHALL have ports: clk in 1 (clock); rst in 1 (reset); time_digits in 42 (six 7-bit patterns, [41:35]=hrs tens ... [6:0]=secs units); alt_digits in 42 (alarm/set-mode patterns, same packing); alt_req in 1 (level, request alt source); blink_mask in 6 (bit k blinks digit k); seg_out out 7 (segment bus); digit_sel out 6 (one-hot enable of driven digit); frame_start out 1; src_alt out 1 (1 = alt source active); alt_ack out 1 (switch pulse).

Function
REQ-007 SHALL keep frame counter cnt counting 1..FRAME_LEN, +1 per cycle, wrapping FRAME_LEN->1.
REQ-008 SHALL, on the edge leaving cnt==FRAME_LEN, snapshot the selected source (alt_digits if next src_alt=1 else time_digits) into a 42-bit frame buffer; buffer unchanged for the rest of the frame.
REQ-009 SHALL assert frame_start for exactly the one cycle in which cnt==1.
REQ-010 SHALL drive per-slot FSM states WAIT->DRIVE->BLANK->WAIT: DRIVE entered on the edge where cnt==SLOTk; lasts ON_LEN cycles; BLANK lasts 1 cycle; then WAIT.
REQ-011 SHALL, in DRIVE for digit k, output seg_out=buffer digit k and digit_sel=1<<k (registered, 1-cycle latency from cnt==SLOTk).
REQ-012 SHALL, in WAIT/BLANK, output seg_out=7'b0000000 and digit_sel=6'b000000.
REQ-013 SHALL, in DRIVE for k with blink_mask[k]=1 and blink_phase=1, output seg_out=0 while still asserting digit_sel.
REQ-014 SHALL toggle blink_phase at the frame boundary after every BLINK_FRAMES frames.
REQ-015 SHALL sample alt_req only at the cnt==FRAME_LEN edge; if it differs from src_alt, src_alt takes the new value and alt_ack pulses 1 cycle (aligned with frame_start).
REQ-016 SHALL ignore alt_req toggles not present at the boundary sample (no mid-frame source change, no ack).
REQ-017 SHALL apply a simultaneous blink toggle and source switch together at the same boundary.
REQ-018 SHALL size cnt as clog2(FRAME_LEN+1) bits; no overflow path exists.
REQ-019 SHALL reject at elaboration: SLOTs not strictly increasing, SLOT0<1, SLOTk+ON_LEN+1>SLOTk+1, SLOT5+ON_LEN+1>FRAME_LEN, ON_LEN<1, or BLINK_FRAMES<1.

Reset
REQ-020 SHALL on rst=1, asynchronously: cnt=1, all slots WAIT, seg_out=0, digit_sel=0, frame_start=0, src_alt=0, alt_ack=0, blink_phase=0, blink frame counter=0, buffer=0.
REQ-021 SHALL, after rst release mid-frame or at power-up, display a blank first frame (buffer=0), then normal operation from the next frame.
REQ-022 SHALL abort any DRIVE in progress immediately on rst assertion.

Structure
REQ-023 SHALL take NUM_DIGITS=6, SEG_W=7, SEG_BLANK=7'b0 and the default FRAME_LEN from shared package seg_pkg.
REQ-024 SHALL implement cnt, frame_start and boundary strobe in sub-module frame_timer; slot FSMs, buffer, blink and source arbitration stay in the top.

Verification
REQ-025 SHALL check reset: rst pulse mid-DRIVE -> seg_out=0, digit_sel=0 same cycle; first post-reset frame fully blank.
REQ-026 SHALL check slot timing: time_digits digit0=7'h06, digit5=7'h7F -> seg_out=7'h06, digit_sel=6'b000001 in the cycle after cnt==1 of frame 2; 7'h7F, 6'b100000 the cycle after cnt==62; 0 at all other cycles.
REQ-027 SHALL check source switch: alt_req=1 raised at cnt==400 -> no change that frame; src_alt=1 and alt_ack single pulse with frame_start; next frame shows alt_digits.
REQ-028 SHALL check glitch filter: alt_req high cnt 100..200 only -> src_alt stays 0, alt_ack never asserts.
REQ-029 SHALL check blink with BLINK_FRAMES=2: blink_mask=6'b000011 -> digits 0,1 blank in frames 3-4 and driven in 5-6; digit_sel still pulses.
REQ-030 SHALL check snapshot coherence: time_digits changed at cnt==30 -> digits 2-5 of that frame still show the old snapshot.
